// File: rtl/imu_pkg.sv
// Shared definitions for the IMU sequencer slice.
// Holds the MPU-9250 register map subset used here, the SPI read flag,
// the power-on init table, the sequencer and frame state enumerations and
// the burst-read length.
package imu_pkg;

  localparam logic [7:0] REG_SMPLRT_DIV   = 8'h19;
  localparam logic [7:0] REG_CONFIG       = 8'h1A;
  localparam logic [7:0] REG_GYRO_CONFIG  = 8'h1B;
  localparam logic [7:0] REG_ACCEL_CONFIG = 8'h1C;
  localparam logic [7:0] REG_ACCEL_XOUT_H = 8'h3B;
  localparam logic [7:0] REG_USER_CTRL    = 8'h6A;
  localparam logic [7:0] REG_PWR_MGMT_1   = 8'h6B;

  // Address bit7 selects a read; it is cleared for writes.
  localparam logic [7:0] SPI_READ  = 8'h80;
  localparam logic [7:0] SPI_DUMMY = 8'hFF;

  localparam logic [2:0] INIT_LAST  = 3'd6;
  localparam int         BURST_LEN  = 14;
  localparam logic [3:0] BURST_LAST = 4'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    CFG_GAP, CFG_ADDR, CFG_DATA, CFG_WAIT, IDLE, RD_ADDR, RD_BYTE, RD_DONE
  } imu_state_t;

  typedef enum logic [1:0] {
    FR_IDLE, FR_START, FR_WAIT
  } frame_state_t;

  // Power-on init table as {address, data}; entry 0 is the device reset.
  function automatic logic [15:0] init_entry(input logic [2:0] idx,
                                             input logic [7:0] gyr_fsr,
                                             input logic [7:0] acc_fsr,
                                             input logic [7:0] dlpf_cfg);
    case (idx)
      3'd0:    init_entry = {REG_PWR_MGMT_1, 8'h80};
      3'd1:    init_entry = {REG_PWR_MGMT_1, 8'h01};
      3'd2:    init_entry = {REG_USER_CTRL, 8'h10};
      3'd3:    init_entry = {REG_GYRO_CONFIG, gyr_fsr};
      3'd4:    init_entry = {REG_ACCEL_CONFIG, acc_fsr};
      3'd5:    init_entry = {REG_CONFIG, dlpf_cfg};
      default: init_entry = {REG_SMPLRT_DIV, 8'h00};
    endcase
  endfunction

endpackage

// File: rtl/imu_spi_frame.sv
// Single-byte handshake with spi_master plus chip-select framing.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   send, tx_byte       one-cycle request to transmit tx_byte (only while idle)
//   cs_release          one-cycle request to raise imu_cs_n (ends the frame)
//   done, rx_byte       one-cycle completion pulse with the received byte
//   gap_done            imu_cs_n has been high for at least CS_GAP cycles
//   spi_start/spi_data_in/spi_busy/spi_new_data/spi_data_out  spi_master side
//   imu_cs_n            IMU chip select, active low
module imu_spi_frame
  import imu_pkg::*;
#(
  parameter int CS_GAP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] tx_byte,
  input  logic       cs_release,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       gap_done,
  output logic       spi_start,
  output logic [7:0] spi_data_in,
  input  logic       spi_busy,
  input  logic       spi_new_data,
  input  logic [7:0] spi_data_out,
  output logic       imu_cs_n
);

  localparam int GW = $clog2(CS_GAP + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(CS_GAP);

  frame_state_t fst;
  logic [GW-1:0] gap_cnt;

  assign gap_done = imu_cs_n && (gap_cnt == GAP_MAX);

  // The byte is latched and cs dropped on the request edge, so cs_n is low
  // one cycle before the registered start; the gap counter only runs while
  // cs_n is high and saturates at CS_GAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      fst         <= FR_IDLE;
      spi_start   <= 1'b0;
      spi_data_in <= 8'hFF;
      imu_cs_n    <= 1'b1;
      gap_cnt     <= '0;
      done        <= 1'b0;
      rx_byte     <= 8'h00;
    end else begin
      spi_start <= 1'b0;
      done      <= 1'b0;
      if (!imu_cs_n)
        gap_cnt <= '0;
      else if (gap_cnt != GAP_MAX)
        gap_cnt <= gap_cnt + 1'b1;
      if (cs_release)
        imu_cs_n <= 1'b1;
      case (fst)
        FR_IDLE: if (send) begin
          spi_data_in <= tx_byte;
          imu_cs_n    <= 1'b0;
          fst         <= FR_START;
        end
        FR_START: if (!spi_busy) begin
          spi_start <= 1'b1;
          fst       <= FR_WAIT;
        end
        FR_WAIT: if (spi_new_data) begin
          rx_byte <= spi_data_out;
          done    <= 1'b1;
          fst     <= FR_IDLE;
        end
        default: fst <= FR_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/imu_sequencer.sv
// IMU sequencer: configures the IMU over SPI after reset, then performs
// 14-byte burst reads on sample_tmr and publishes a coherent sample set.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   sample_tmr          one-cycle sample request
//   spi_*               spi_master byte interface
//   imu_cs_n            IMU chip select, active low
//   ready               configuration finished
//   acc_*, gyr_*        big-endian assembled 16-bit samples
//   new_sample          one-cycle strobe, all six samples updated together
//   overrun             one-cycle pulse when a trigger is dropped
module imu_sequencer
  import imu_pkg::*;
#(
  parameter int         RESET_WAIT = 5000000,
  parameter int         CS_GAP     = 8,
  parameter logic [7:0] GYR_FSR    = 8'h18,
  parameter logic [7:0] ACC_FSR    = 8'h08,
  parameter logic [7:0] DLPF_CFG   = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_tmr,
  output logic        spi_start,
  output logic [7:0]  spi_data_in,
  input  logic        spi_busy,
  input  logic        spi_new_data,
  input  logic [7:0]  spi_data_out,
  output logic        imu_cs_n,
  output logic        ready,
  output logic [15:0] acc_x,
  output logic [15:0] acc_y,
  output logic [15:0] acc_z,
  output logic [15:0] gyr_x,
  output logic [15:0] gyr_y,
  output logic [15:0] gyr_z,
  output logic        new_sample,
  output logic        overrun
);

  localparam logic [22:0] WAIT_LAST = 23'(RESET_WAIT - 1);

  imu_state_t  state;
  logic [2:0]  init_idx;
  logic [22:0] wait_cnt;
  logic [3:0]  byte_cnt;
  logic        issued;
  logic        pending;
  logic        send;
  logic [7:0]  tx_byte;
  logic        cs_release;
  logic        frame_done;
  logic [7:0]  rx_byte;
  logic        gap_done;
  logic [15:0] sh [0:5];
  logic [15:0] entry;
  logic        start_now;
  logic        sh_keep;
  logic        sh_hi;
  logic [2:0]  sh_idx;

  imu_spi_frame #(.CS_GAP(CS_GAP)) u_frame (
    .clk          (clk),
    .rst          (rst),
    .send         (send),
    .tx_byte      (tx_byte),
    .cs_release   (cs_release),
    .done         (frame_done),
    .rx_byte      (rx_byte),
    .gap_done     (gap_done),
    .spi_start    (spi_start),
    .spi_data_in  (spi_data_in),
    .spi_busy     (spi_busy),
    .spi_new_data (spi_new_data),
    .spi_data_out (spi_data_out),
    .imu_cs_n     (imu_cs_n)
  );

  assign entry     = init_entry(init_idx, GYR_FSR, ACC_FSR, DLPF_CFG);
  assign start_now = (state == IDLE) && gap_done && (sample_tmr || pending);

  // Burst bytes 0-5 map to acc shadows 0-2, bytes 8-13 to gyr shadows 3-5;
  // the two temperature bytes are dropped.
  always_comb begin
    sh_keep = (byte_cnt != 4'd6) && (byte_cnt != 4'd7);
    sh_hi   = !byte_cnt[0];
    sh_idx  = (byte_cnt < 4'd6) ? byte_cnt[3:1] : 3'(byte_cnt[3:1] - 3'd1);
  end

  // Each send state issues one byte request, then waits for the frame's
  // completion pulse before advancing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CFG_GAP;
      init_idx   <= 3'd0;
      wait_cnt   <= '0;
      byte_cnt   <= 4'd0;
      issued     <= 1'b0;
      pending    <= 1'b0;
      send       <= 1'b0;
      tx_byte    <= 8'hFF;
      cs_release <= 1'b0;
      ready      <= 1'b0;
      new_sample <= 1'b0;
      overrun    <= 1'b0;
      acc_x      <= '0;
      acc_y      <= '0;
      acc_z      <= '0;
      gyr_x      <= '0;
      gyr_y      <= '0;
      gyr_z      <= '0;
      for (int i = 0; i < 6; i++) sh[i] <= '0;
    end else begin
      send       <= 1'b0;
      cs_release <= 1'b0;
      new_sample <= 1'b0;
      overrun    <= 1'b0;
      if (sample_tmr && ready && !start_now) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end
      case (state)
        CFG_GAP: if (gap_done) state <= CFG_ADDR;
        CFG_ADDR: begin
          if (!issued) begin
            send    <= 1'b1;
            tx_byte <= entry[15:8] & ~SPI_READ;
            issued  <= 1'b1;
          end else if (frame_done) begin
            issued <= 1'b0;
            state  <= CFG_DATA;
          end
        end
        CFG_DATA: begin
          if (!issued) begin
            send    <= 1'b1;
            tx_byte <= entry[7:0];
            issued  <= 1'b1;
          end else if (frame_done) begin
            issued     <= 1'b0;
            cs_release <= 1'b1;
            if (init_idx == 3'd0) begin
              init_idx <= 3'd1;
              wait_cnt <= '0;
              state    <= CFG_WAIT;
            end else if (init_idx == INIT_LAST) begin
              ready <= 1'b1;
              state <= IDLE;
            end else begin
              init_idx <= init_idx + 3'd1;
              state    <= CFG_GAP;
            end
          end
        end
        CFG_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= CFG_GAP;
          else wait_cnt <= wait_cnt + 23'd1;
        end
        IDLE: if (start_now) begin
          // A trigger arriving while a pending one is consumed stays queued.
          pending <= pending && sample_tmr;
          state   <= RD_ADDR;
        end
        RD_ADDR: begin
          if (!issued) begin
            send    <= 1'b1;
            tx_byte <= SPI_READ | REG_ACCEL_XOUT_H;
            issued  <= 1'b1;
          end else if (frame_done) begin
            issued   <= 1'b0;
            byte_cnt <= 4'd0;
            state    <= RD_BYTE;
          end
        end
        RD_BYTE: begin
          if (!issued) begin
            send    <= 1'b1;
            tx_byte <= SPI_DUMMY;
            issued  <= 1'b1;
          end else if (frame_done) begin
            issued <= 1'b0;
            if (sh_keep) begin
              if (sh_hi) sh[sh_idx][15:8] <= rx_byte;
              else       sh[sh_idx][7:0]  <= rx_byte;
            end
            if (byte_cnt == BURST_LAST) begin
              byte_cnt   <= 4'd0;
              cs_release <= 1'b1;
              state      <= RD_DONE;
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end
        RD_DONE: begin
          acc_x      <= sh[0];
          acc_y      <= sh[1];
          acc_z      <= sh[2];
          gyr_x      <= sh[3];
          gyr_y      <= sh[4];
          gyr_z      <= sh[5];
          new_sample <= 1'b1;
          state      <= IDLE;
        end
        default: state <= CFG_GAP;
      endcase
    end
  end

endmodule
